// File: rtl/sdf_frame_sequencer.sv
// Batch sequencer for the SDF FFT: streams frames from the source RAM, flushes, captures results.
// Define SDF_SEQ_BITREV_EN to store natural-order spectra (bit-reversed in-frame write address).
module sdf_frame_sequencer #(
    parameter int unsigned N       = 64,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned FRAME_W = 8,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned LOG_N  = $clog2(N),
    localparam int unsigned AW     = FRAME_W + LOG_N
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [FRAME_W-1:0] num_frames,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               src_rd,
    output logic [AW-1:0]      src_addr,
    input  logic [WIDTH-1:0]   src_re,
    input  logic [WIDTH-1:0]   src_im,
    output logic               fft_clear,
    output logic               fft_din_en,
    output logic [WIDTH-1:0]   fft_din_re,
    output logic [WIDTH-1:0]   fft_din_im,
    input  logic               fft_dout_en,
    input  logic [WIDTH-1:0]   fft_dout_re,
    input  logic [WIDTH-1:0]   fft_dout_im,
    output logic               dst_we,
    output logic [AW-1:0]      dst_addr,
    output logic [WIDTH-1:0]   dst_re,
    output logic [WIDTH-1:0]   dst_im
);
    localparam int unsigned FC_W = LOG_N + 1;
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE} state_t;
    state_t state, next_state;

    logic [FRAME_W-1:0] nf, nf_d;
    logic [AW-1:0]      cc, cc_d, total, src_addr_d, dst_addr_d;
    logic [FC_W-1:0]    fc, fc_d;
    logic [WD_W-1:0]    wd, wd_d;
    logic [LOG_N-1:0]   in_frame_idx;
    logic [WIDTH-1:0]   dst_re_d, dst_im_d;
    logic               din_zero, din_zero_d;
    logic               busy_d, done_d, error_d, src_rd_d, fft_clear_d, din_en_d, dst_we_d;
    logic               kill, accept, flush_rd, wd_active, timeout, wd_fire, capture;

`ifdef SDF_SEQ_BITREV_EN
    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] x);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) r[i] = x[LOG_N-1-i];
        return r;
    endfunction
    assign in_frame_idx = bitrev(cc[LOG_N-1:0]);
`else
    assign in_frame_idx = cc[LOG_N-1:0];
`endif

    assign total     = {nf, LOG_N'(0)};
    assign kill      = (state != IDLE) && abort;
    assign accept    = (state == IDLE) && start && !abort;
    assign flush_rd  = (state == FLUSH) && (fc < FC_W'(N));
    assign wd_active = (state == FLUSH) || (state == DRAIN);
    assign timeout   = wd_active && !fft_dout_en && (wd == WD_W'(TIMEOUT - 1));
    assign wd_fire   = timeout && !kill && (next_state == IDLE);
    assign capture   = !kill && (state != IDLE) && fft_dout_en && (cc < total);

    // The first FLUSH cycle still carries the last real sample, so FLUSH lasts N+1 cycles.
    assign fft_din_re = (fft_din_en && !din_zero) ? src_re : '0;
    assign fft_din_im = (fft_din_en && !din_zero) ? src_im : '0;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        next_state = state;
        if (kill) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) next_state = (num_frames == '0) ? DONE : CLEAR;
                CLEAR:   next_state = FEED;
                FEED:    if (src_addr == total - AW'(1)) next_state = FLUSH;
                FLUSH: begin
                    if (timeout)                 next_state = IDLE;
                    else if (fc == FC_W'(N))     next_state = DRAIN;
                end
                DRAIN: begin
                    if (cc == total)             next_state = DONE;
                    else if (timeout)            next_state = IDLE;
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Next values of registered outputs and counters
    always_comb begin
        busy_d      = (next_state != IDLE) && (next_state != DONE);
        done_d      = (next_state == DONE);
        error_d     = error;
        fft_clear_d = kill || wd_fire || (next_state == CLEAR);
        src_rd_d    = (next_state == FEED);
        src_addr_d  = src_addr;
        din_en_d    = !kill && !wd_fire && (src_rd || flush_rd);
        din_zero_d  = flush_rd;
        dst_we_d    = capture;
        dst_addr_d  = dst_addr;
        dst_re_d    = dst_re;
        dst_im_d    = dst_im;
        nf_d        = nf;
        cc_d        = cc;
        fc_d        = (state == FLUSH) ? fc + FC_W'(1) : '0;
        wd_d        = (wd_active && !fft_dout_en) ? wd + WD_W'(1) : '0;
        if (accept) begin
            nf_d    = num_frames;
            cc_d    = '0;
            error_d = 1'b0;
        end
        if (wd_fire) error_d = 1'b1;
        if (next_state == FEED) src_addr_d = (state == FEED) ? src_addr + AW'(1) : '0;
        if (capture) begin
            cc_d       = cc + AW'(1);
            dst_addr_d = {cc[AW-1:LOG_N], in_frame_idx};
            dst_re_d   = fft_dout_re;
            dst_im_d   = fft_dout_im;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            src_rd     <= 1'b0;
            src_addr   <= '0;
            fft_clear  <= 1'b0;
            fft_din_en <= 1'b0;
            din_zero   <= 1'b0;
            dst_we     <= 1'b0;
            dst_addr   <= '0;
            dst_re     <= '0;
            dst_im     <= '0;
            nf         <= '0;
            cc         <= '0;
            fc         <= '0;
            wd         <= '0;
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            src_rd     <= src_rd_d;
            src_addr   <= src_addr_d;
            fft_clear  <= fft_clear_d;
            fft_din_en <= din_en_d;
            din_zero   <= din_zero_d;
            dst_we     <= dst_we_d;
            dst_addr   <= dst_addr_d;
            dst_re     <= dst_re_d;
            dst_im     <= dst_im_d;
            nf         <= nf_d;
            cc         <= cc_d;
            fc         <= fc_d;
            wd         <= wd_d;
        end
    end
endmodule
